// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file writeback path
package regfile_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int AW   = 4;
    typedef enum logic {WB_ALU = 1'b0, WB_LSU = 1'b1} wb_src_e;
    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] wd;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// regfile_wb_ctrl_if: issue, writeback request and register-file write port bundle
interface regfile_wb_ctrl_if import regfile_pkg::*; ;
    logic            issue_valid;
    logic [AW-1:0]   issue_rs1;
    logic [AW-1:0]   issue_rs2;
    logic [AW-1:0]   issue_rd;
    logic            issue_wr;
    logic            issue_ready;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_wd;
    logic            alu_ready;
    logic            lsu_valid;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_wd;
    logic            lsu_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic [NREG-1:0] busy;
    logic            wb_err;
    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
        output alu_valid, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd,
        input  issue_ready, alu_ready, lsu_ready, rf_we, rf_rd, rf_wd, busy, wb_err
    );
    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
        input  alu_valid, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd,
        output issue_ready, alu_ready, lsu_ready, rf_we, rf_rd, rf_wd, busy, wb_err
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; the pointer names the side favoured on conflict
module rr_arb2 import regfile_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_alu,
    input  logic i_req_lsu,
    output logic o_gnt_alu,
    output logic o_gnt_lsu
);
    wb_src_e r_ptr;
    wb_src_e w_ptr_nxt;
    // sole requester wins, pointer side wins a conflict, pointer then moves to the loser
    always_comb begin
        o_gnt_alu = i_req_alu && (!i_req_lsu || r_ptr == WB_ALU);
        o_gnt_lsu = i_req_lsu && !o_gnt_alu;
        w_ptr_nxt = o_gnt_alu ? WB_LSU : (o_gnt_lsu ? WB_ALU : r_ptr);
    end
    // pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ptr <= WB_ALU;
        else        r_ptr <= w_ptr_nxt;
    end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: writeback arbitration, pending-write scoreboard and issue hazard check
module regfile_wb_ctrl import regfile_pkg::*; (
    input logic               clk,
    input logic               rst_n,
    regfile_wb_ctrl_if.slave  bus
);
    logic            w_gnt_alu;
    logic            w_gnt_lsu;
    logic            w_wr;
    logic            w_fire;
    wb_req_t         w_req;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] r_busy;
    logic            r_we;
    logic [AW-1:0]   r_rd;
    logic [XLEN-1:0] r_wd;
    logic            r_err;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req_alu (bus.alu_valid),
        .i_req_lsu (bus.lsu_valid),
        .o_gnt_alu (w_gnt_alu),
        .o_gnt_lsu (w_gnt_lsu)
    );

    // hazard check, granted request mux and scoreboard set/clear masks; x0 is never tracked
    always_comb begin
        bus.issue_ready = !(r_busy[bus.issue_rs1] && bus.issue_rs1 != '0)
                       && !(r_busy[bus.issue_rs2] && bus.issue_rs2 != '0)
                       && !(bus.issue_wr && r_busy[bus.issue_rd] && bus.issue_rd != '0);
        w_fire = bus.issue_valid && bus.issue_ready && bus.issue_wr && bus.issue_rd != '0;
        w_req  = w_gnt_lsu ? {bus.lsu_rd, bus.lsu_wd} : {bus.alu_rd, bus.alu_wd};
        w_wr   = (w_gnt_alu || w_gnt_lsu) && w_req.rd != '0;
        w_set  = w_fire ? NREG'(1) << bus.issue_rd : '0;
        w_clr  = r_we ? NREG'(1) << r_rd : '0;
    end

    // scoreboard clears on the register-file write edge; a same-edge issue re-sets the bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= (r_busy & ~w_clr) | w_set;
    end

    // registered write port and sticky error for writes nobody was waiting on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we  <= 1'b0;
            r_rd  <= '0;
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_we  <= w_wr;
            if (w_wr) begin
                r_rd <= w_req.rd;
                r_wd <= w_req.wd;
            end
            r_err <= r_err || (w_wr && !r_busy[w_req.rd]);
        end
    end

    // drive the bus outputs
    always_comb begin
        bus.alu_ready = w_gnt_alu;
        bus.lsu_ready = w_gnt_lsu;
        bus.rf_we     = r_we;
        bus.rf_rd     = r_rd;
        bus.rf_wd     = r_wd;
        bus.busy      = r_busy;
        bus.wb_err    = r_err;
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed and random stimulus against a scoreboard reference model
module tb_regfile_wb_ctrl;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    regfile_wb_ctrl_if bus ();
    regfile_wb_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] wd;
    } wr_t;

    int              n_chk = 0;
    int              n_fail = 0;
    wr_t             wq[$];
    wr_t             mon_e;
    bit              pend[NREG];
    bit              m_ptr_lsu, m_err, m_we, m_nwe, m_ga, m_gl, m_ir;
    logic [AW-1:0]   m_rd, m_wrd;
    logic [XLEN-1:0] m_wwd;
    logic [NREG-1:0] m_bv;
    logic            ga, gl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hz(input logic [AW-1:0] r);
        return r != '0 && pend[r];
    endfunction

    // reference model: pending set, round-robin turn, sticky error, expected writes
    always @(negedge clk) begin
        if (!rst_n) begin
            foreach (pend[i]) pend[i] = 1'b0;
            m_ptr_lsu = 1'b0;
            m_err     = 1'b0;
            m_we      = 1'b0;
            m_rd      = '0;
            wq.delete();
        end else begin
            foreach (pend[i]) m_bv[i] = pend[i];
            chk("busy", bus.busy, m_bv);
            chk("wb_err", bus.wb_err, m_err);
            chk("rf_we", bus.rf_we, m_we);
            m_ir = !hz(bus.issue_rs1) && !hz(bus.issue_rs2) && !(bus.issue_wr && hz(bus.issue_rd));
            if (bus.alu_valid && bus.lsu_valid) begin
                m_ga = !m_ptr_lsu;
                m_gl = m_ptr_lsu;
            end else begin
                m_ga = bus.alu_valid;
                m_gl = bus.lsu_valid;
            end
            chk("issue_ready", bus.issue_ready, m_ir);
            chk("alu_ready", bus.alu_ready, m_ga);
            chk("lsu_ready", bus.lsu_ready, m_gl);
            m_wrd = m_gl ? bus.lsu_rd : bus.alu_rd;
            m_wwd = m_gl ? bus.lsu_wd : bus.alu_wd;
            if (m_ga || m_gl) m_ptr_lsu = m_ga;
            m_nwe = (m_ga || m_gl) && m_wrd != '0;
            if (m_nwe) begin
                if (!pend[m_wrd]) m_err = 1'b1;
                wq.push_back('{rd: m_wrd, wd: m_wwd});
            end
            if (m_we) pend[m_rd] = 1'b0;
            if (bus.issue_valid && m_ir && bus.issue_wr && bus.issue_rd != '0) pend[bus.issue_rd] = 1'b1;
            m_we = m_nwe;
            if (m_nwe) m_rd = m_wrd;
        end
    end

    // monitor: every register-file write must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && bus.rf_we) begin
            if (wq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got rd %0h wd %0h expected none", bus.rf_rd, bus.rf_wd);
            end else begin
                mon_e = wq.pop_front();
                chk("rf_rd", bus.rf_rd, mon_e.rd);
                chk("rf_wd", bus.rf_wd, mon_e.wd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 0; bus.issue_rs1 = '0; bus.issue_rs2 = '0; bus.issue_rd = '0; bus.issue_wr = 0;
        bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_wd = '0;
        bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_wd = '0;
    endtask

    task automatic randin();
        bus.issue_valid = 1'($urandom); bus.issue_wr = 1'($urandom);
        bus.issue_rs1 = AW'($urandom); bus.issue_rs2 = AW'($urandom); bus.issue_rd = AW'($urandom);
        bus.alu_valid = 1'($urandom); bus.alu_rd = AW'($urandom); bus.alu_wd = $urandom;
        bus.lsu_valid = 1'($urandom); bus.lsu_rd = AW'($urandom); bus.lsu_wd = $urandom;
    endtask

    task automatic pulse_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [AW-1:0] pick_rd();
        logic [AW-1:0] r;
        for (int t = 0; t < 4; t++) begin
            r = AW'($urandom);
            if (pend[r]) return r;
        end
        return r;
    endfunction

    initial begin
        idle();
        repeat (3) begin
            step();
            randin();
        end
        @(negedge clk);
        chk("rst_rf_we", bus.rf_we, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wb_err", bus.wb_err, 0);
        step();
        idle();
        rst_n = 1'b1;

        bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_wd = 32'hDEADBEEF;
        #2 chk("first_alu_ready", bus.alu_ready, 1);
        step();
        bus.alu_valid = 0;
        chk("first_rf_we", bus.rf_we, 1);
        chk("first_rf_rd", bus.rf_rd, 3);
        chk("first_rf_wd", bus.rf_wd, 32'hDEADBEEF);
        pulse_reset();

        bus.issue_valid = 1; bus.issue_wr = 1; bus.issue_rd = 5;
        #2 chk("raw_issue_ready", bus.issue_ready, 1);
        step();
        bus.issue_wr = 0; bus.issue_rs1 = 5;
        #2 chk("raw_stall", bus.issue_ready, 0);
        step();
        bus.issue_valid = 0;
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_wd = 32'h5555AAAA;
        #2 chk("raw_grant", bus.alu_ready, 1);
        chk("raw_stall_n", bus.issue_ready, 0);
        step();
        bus.alu_valid = 0;
        #2 chk("raw_stall_n1", bus.issue_ready, 0);
        chk("raw_rf_we_n1", bus.rf_we, 1);
        step();
        #2 chk("raw_ready_n2", bus.issue_ready, 1);
        chk("raw_busy5", bus.busy[5], 0);
        pulse_reset();

        bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_wd = 32'hA1;
        bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_wd = 32'hB2;
        for (int k = 0; k < 4; k++) begin
            #2 chk("conf_alu_ready", bus.alu_ready, k % 2 == 0);
            chk("conf_lsu_ready", bus.lsu_ready, k % 2 == 1);
            step();
            chk("conf_rf_we", bus.rf_we, 1);
            chk("conf_rf_rd", bus.rf_rd, (k % 2 == 0) ? 1 : 2);
        end
        bus.alu_valid = 0;
        #2 chk("lsu_only_ready", bus.lsu_ready, 1);
        step();
        bus.lsu_valid = 0;
        chk("lsu_only_rf_rd", bus.rf_rd, 2);
        pulse_reset();

        bus.issue_valid = 1; bus.issue_wr = 1; bus.issue_rd = 0;
        step();
        bus.issue_valid = 0; bus.issue_wr = 0;
        chk("x0_issue_busy", bus.busy, 0);
        bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_wd = 32'h123;
        #2 chk("x0_alu_ready", bus.alu_ready, 1);
        step();
        bus.alu_valid = 0;
        chk("x0_rf_we", bus.rf_we, 0);
        chk("x0_wb_err", bus.wb_err, 0);
        chk("x0_busy", bus.busy, 0);
        bus.issue_valid = 1; bus.issue_wr = 1; bus.issue_rd = 4;
        step();
        bus.issue_valid = 0; bus.issue_wr = 0;
        #2 chk("x0_busy4", bus.busy, 16'h0010);
        chk("x0_rs_ready", bus.issue_ready, 1);
        bus.issue_rs1 = 4;
        #1 chk("rs4_stall", bus.issue_ready, 0);
        bus.issue_rs1 = 0;

        bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_wd = 32'h77;
        step();
        bus.alu_valid = 0;
        chk("err_rf_we", bus.rf_we, 1);
        chk("err_set", bus.wb_err, 1);
        repeat (3) step();
        chk("err_sticky", bus.wb_err, 1);
        pulse_reset();

        bus.issue_valid = 1; bus.issue_wr = 1; bus.issue_rd = 9;
        step();
        bus.issue_valid = 0; bus.issue_wr = 0;
        bus.alu_valid = 1; bus.alu_rd = 8; bus.alu_wd = 32'h88;
        step();
        bus.alu_valid = 0;
        chk("midrst_pre_we", bus.rf_we, 1);
        chk("midrst_pre_busy", bus.busy, 16'h0200);
        #2 rst_n = 1'b0;
        #1 chk("midrst_we", bus.rf_we, 0);
        chk("midrst_busy", bus.busy, 0);
        step();
        step();
        rst_n = 1'b1;
        bus.alu_valid = 1; bus.alu_rd = 1; bus.lsu_valid = 1; bus.lsu_rd = 2;
        #2 chk("midrst_ptr_alu", bus.alu_ready, 1);
        chk("midrst_ptr_lsu", bus.lsu_ready, 0);
        step();
        pulse_reset();

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ga = bus.alu_ready;
            gl = bus.lsu_ready;
            step();
            if (!bus.alu_valid || ga) begin
                bus.alu_valid = 1'($urandom); bus.alu_rd = pick_rd(); bus.alu_wd = $urandom;
            end
            if (!bus.lsu_valid || gl) begin
                bus.lsu_valid = 1'($urandom); bus.lsu_rd = pick_rd(); bus.lsu_wd = $urandom;
            end
            bus.issue_valid = 1'($urandom); bus.issue_wr = ($urandom_range(0, 9) < 7);
            bus.issue_rs1 = AW'($urandom); bus.issue_rs2 = AW'($urandom); bus.issue_rd = AW'($urandom);
        end
        idle();
        repeat (4) step();
        chk("wq_drained", wq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Writeback controller and scoreboard for the 16-entry, 32-bit register file. Arbitrates the ALU and load/store unit onto the register file's single write port, drives its `we`/`rd`/`wd` inputs from registered outputs, and tracks per-register pending writes. Sits between decode/issue and the register file. Stalls issue on RAW and WAW hazards against in-flight writebacks.

## Interface
- `XLEN`, default 32: data width.
- `NREG`, default 16: register count.
- `AW`, default 4: register index width.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `issue_valid` in 1: decode presents an instruction.
- `issue_rs1`, `issue_rs2`, `issue_rd` in AW: source and destination indices.
- `issue_wr` in 1: instruction writes `issue_rd`.
- `issue_ready` out 1: no hazard; instruction may issue.
- `alu_valid` in 1, `alu_rd` in AW, `alu_wd` in XLEN: ALU writeback request.
- `alu_ready` out 1: ALU request granted this cycle.
- `lsu_valid` in 1, `lsu_rd` in AW, `lsu_wd` in XLEN: LSU writeback request.
- `lsu_ready` out 1: LSU request granted this cycle.
- `rf_we` out 1, `rf_rd` out AW, `rf_wd` out XLEN: register file write port.
- `busy` out NREG: scoreboard, bit i = write to register i pending.
- `wb_err` out 1: sticky, writeback to a non-busy nonzero register.

## Operation
- Reset values: `rf_we`=0, `rf_rd`=0, `rf_wd`=0, `busy`=0, `wb_err`=0, priority pointer = ALU.
- Issue hazard: `issue_ready` = !(`busy`[rs1] && rs1≠0) && !(`busy`[rs2] && rs2≠0) && !(`issue_wr` && `busy`[rd] && rd≠0). It is combinational and independent of `issue_valid`.
- Issue fire (`issue_valid` && `issue_ready`) with `issue_wr` and rd≠0 sets `busy`[rd] at the next edge.
- Valid/ready handshake on both writeback ports. A requester holds valid, rd and wd stable until ready.
- Arbitration is two-way round-robin:
  - Sole requester is granted.
  - On conflict, the pointer side is granted.
  - After any grant, the pointer moves to the non-granted side.
  - The pointer holds when there is no grant.
- `alu_ready`/`lsu_ready` are combinational from valids and pointer. At most one is high.
- Grant with rd≠0: next edge registers `rf_we`=1, `rf_rd`, `rf_wd`.
- Grant with rd=0: accepted and consumed, `rf_we`=0, no scoreboard change.
- Grant with rd≠0 and `busy`[rd]=0 sets `wb_err`. The write still proceeds. `wb_err` clears only on reset.
- `busy`[r] clears on the edge where `rf_we`=1 and `rf_rd`=r, i.e. the same edge that writes the register file.
- Same-edge set and clear of the same bit: set wins.
- `busy`[0] is constantly 0.

## Timing
- Grant in cycle N. `rf_we` is high in cycle N+1. The register file and `busy` update at the end of N+1.
- In cycle N+2, a dependent instruction sees `issue_ready`=1 and the register file returns the new value.
- Minimum RAW stall is therefore 2 cycles after grant. There is no bypass.
- Issue fire in cycle N: `busy`[rd]=1 from cycle N+1. A second instruction reading rd in N+1 stalls.
- Throughput is one writeback per cycle. The write port stays busy in back-to-back cycles under continuous grants.
- Reset asserted mid-operation:
  - Outputs return to reset values immediately and asynchronously.
  - An in-flight `rf_we` is dropped and pending grants are lost.
  - Requesters must re-present after `rst_n` deasserts.

## Structure
- Shared package `regfile_pkg`:
  - Constants `XLEN`, `NREG`, `AW`.
  - Requester enum `wb_src_e` {WB_ALU, WB_LSU}.
  - Writeback request struct {rd, wd}.
- Natural sub-module: `rr_arb2`, a two-requester round-robin arbiter with pointer register, reset to WB_ALU.
- Scoreboard, hazard check and write-port register stay in the top module.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `rf_we`=0, `busy`=0, `wb_err`=0. After release, `alu_valid` alone with rd=3, wd=32'hDEADBEEF → `alu_ready`=1, next cycle `rf_we`=1, `rf_rd`=3, `rf_wd`=32'hDEADBEEF.
- RAW stall:
  - Issue rd=5, then issue rs1=5 → `issue_ready`=0.
  - ALU writeback rd=5 granted in cycle N → `issue_ready` stays 0 in N+1, becomes 1 in N+2, `busy`[5]=0.
- Conflict:
  - Both valid for 4 cycles (ALU rd=1, LSU rd=2, each re-presenting after grant) → grants alternate ALU, LSU, ALU, LSU, `rf_we` high for 4 consecutive cycles.
  - Then only LSU valid → LSU granted.
- x0: issue rd=0 then writeback rd=0 → `busy` unchanged, `rf_we`=0, `wb_err`=0. Issue rs1=0 always sees `issue_ready`=1.
- Error: writeback rd=7 with `busy`[7]=0 → `rf_we`=1 next cycle, `wb_err`=1 and stays set.
- Mid-op reset: assert `rst_n`=0 in the cycle `rf_we`=1 → `rf_we` drops asynchronously, `busy` clears, pointer returns to ALU.
